idu_scoreboard: RTL and testbench

//  Register-hazard scoreboard between the decoder and the execute stage.

---
 rtl/idu_scoreboard_pkg.sv | 21 ++
 rtl/idu_scoreboard_if.sv | 44 ++++
 rtl/idu_scoreboard_scb_cnt.sv | 56 +++++
 rtl/idu_scoreboard.sv | 104 ++++++++++
 tb/tb_idu_scoreboard.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idu_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// idu_scoreboard_pkg
// Shared sizing constants and helpers for the IDU register-hazard scoreboard.
//   REG_ADDRW   : width of a GPR index
//   SCB_REG_NUM : number of GPRs (x0 is never tracked)
//   SCB_CNT_W   : width of each per-register pending-write counter
// -----------------------------------------------------------------------------
package idu_scoreboard_pkg;

  localparam int REG_ADDRW   = 5;
  localparam int SCB_REG_NUM = 32;
  localparam int SCB_CNT_W   = 2;

  typedef logic [REG_ADDRW-1:0] regId_t;

  // x0 is hardwired to zero, so it can never carry a pending write.
  function automatic logic isTracked(input regId_t id);
    return id != '0;
  endfunction

endpackage

// File: rtl/idu_scoreboard_if.sv
// -----------------------------------------------------------------------------
// idu_scoreboard_if
// Bundles the decoded-instruction fields, the IDU->EXU valid/ready handshake,
// the writeback/retire notifications, flush and the status outputs.
//   slave  : the scoreboard (consumes decode/wb info, drives o_* outputs)
//   master : the decoder/EXU side (drives i_* inputs, observes o_* outputs)
// -----------------------------------------------------------------------------
interface idu_scoreboard_if;
  import idu_scoreboard_pkg::*;

  regId_t i_rs1id;
  logic   i_rs1ren;
  regId_t i_rs2id;
  logic   i_rs2ren;
  regId_t i_rdid;
  logic   i_rdwen;
  logic   i_sysins;
  logic   i_csrdwen;
  logic   i_pre_valid;
  logic   o_pre_ready;
  logic   o_post_valid;
  logic   i_post_ready;
  logic   i_wb_valid;
  regId_t i_wb_rdid;
  logic   i_wb_csr;
  logic   i_flush;
  logic   o_stall;
  logic   o_wb_err;

  modport slave (
    input  i_rs1id, i_rs1ren, i_rs2id, i_rs2ren, i_rdid, i_rdwen,
    input  i_sysins, i_csrdwen, i_pre_valid, i_post_ready,
    input  i_wb_valid, i_wb_rdid, i_wb_csr, i_flush,
    output o_pre_ready, o_post_valid, o_stall, o_wb_err
  );

  modport master (
    output i_rs1id, i_rs1ren, i_rs2id, i_rs2ren, i_rdid, i_rdwen,
    output i_sysins, i_csrdwen, i_pre_valid, i_post_ready,
    output i_wb_valid, i_wb_rdid, i_wb_csr, i_flush,
    input  o_pre_ready, o_post_valid, o_stall, o_wb_err
  );

endinterface

// File: rtl/idu_scoreboard_scb_cnt.sv
// -----------------------------------------------------------------------------
// scb_cnt
// Pending-write counter for a single GPR.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_inc          : an instruction writing this register issued
//   i_dec          : a writeback to this register retired (ignored at zero)
//   i_clr          : flush, wins over inc/dec
//   o_cnt          : current count
//   o_nz           : count is non-zero (a write is pending)
//   o_full         : count is at its maximum (no further issue allowed)
// -----------------------------------------------------------------------------
module scb_cnt
  import idu_scoreboard_pkg::*;
#(
  parameter int CNT_W = SCB_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_nz,
  output logic             o_full
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_inc;
  logic             w_dec;

  // A retire against an empty counter is a stray writeback, not a decrement.
  // An increment at the maximum only counts when a decrement cancels it, so
  // the counter can never wrap even if the issue gating were bypassed.
  assign w_dec = i_dec & (r_cnt != '0);
  assign w_inc = i_inc & (w_dec | (r_cnt != CNT_MAX));

  // Count up on issue, down on retire; matching inc/dec cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (w_inc & ~w_dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dec & ~w_inc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_nz   = (r_cnt != '0);
  assign o_full = (r_cnt == CNT_MAX);

endmodule

// File: rtl/idu_scoreboard.sv
// -----------------------------------------------------------------------------
// idu_scoreboard
// Register-hazard scoreboard between the decoder and the execute stage. It
// counts in-flight GPR writes and holds the IDU->EXU handshake while a source
// has a pending write or a destination counter is saturated.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : decode fields, pre/post valid-ready, writeback, flush,
//                    o_stall (debug/perf) and sticky o_wb_err
// Optional feature macro: IDU_SCB_CSR_EN
//   defined   : a pending CSR write blocks every SYSTEM instruction until the
//               CSR write retires (i_wb_csr)
//   undefined : i_sysins/i_csrdwen/i_wb_csr are ignored, no CSR hazard
// -----------------------------------------------------------------------------
module idu_scoreboard
  import idu_scoreboard_pkg::*;
#(
  parameter int REG_NUM = SCB_REG_NUM,
  parameter int CNT_W   = SCB_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  idu_scoreboard_if.slave  bus
);

  logic [REG_NUM-1:0] w_nz;
  logic [REG_NUM-1:0] w_full;
  logic [CNT_W-1:0]   w_cnt [REG_NUM];
  logic               w_csrHazard;
  logic               w_hazard;
  logic               w_postValid;
  logic               w_issue;
  logic               r_wbErr;

  // Hazard is evaluated purely from registered counts: a writeback landing
  // this cycle does not release a dependent instruction until the next one.
  assign w_hazard = (bus.i_rs1ren & isTracked(bus.i_rs1id) & w_nz[bus.i_rs1id])
                  | (bus.i_rs2ren & isTracked(bus.i_rs2id) & w_nz[bus.i_rs2id])
                  | (bus.i_rdwen  & isTracked(bus.i_rdid)  & w_full[bus.i_rdid])
                  | w_csrHazard;

  assign w_postValid      = bus.i_pre_valid & ~w_hazard & ~bus.i_flush;
  assign w_issue          = w_postValid & bus.i_post_ready;
  assign bus.o_post_valid = w_postValid;
  assign bus.o_pre_ready  = bus.i_post_ready & ~w_hazard & ~bus.i_flush;
  assign bus.o_stall      = bus.i_pre_valid & w_hazard;
  assign bus.o_wb_err     = r_wbErr;

  // x0 has no counter; its slots read as permanently empty.
  assign w_nz[0]   = 1'b0;
  assign w_full[0] = 1'b0;
  assign w_cnt[0]  = '0;

  for (genvar r = 1; r < REG_NUM; r++) begin : gCnt
    scb_cnt #(
      .CNT_W (CNT_W)
    ) uCnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (w_issue & bus.i_rdwen & (bus.i_rdid == REG_ADDRW'(r))),
      .i_dec   (bus.i_wb_valid & (bus.i_wb_rdid == REG_ADDRW'(r))),
      .i_clr   (bus.i_flush),
      .o_cnt   (w_cnt[r]),
      .o_nz    (w_nz[r]),
      .o_full  (w_full[r])
    );
  end

  // Sticky error for a writeback to a register with nothing pending. A flush
  // cycle discards the writeback entirely, so it cannot raise the error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wbErr <= 1'b0;
    end else if (bus.i_wb_valid & ~bus.i_flush & isTracked(bus.i_wb_rdid)
                 & (w_cnt[bus.i_wb_rdid] == '0)) begin
      r_wbErr <= 1'b1;
    end
  end

`ifdef IDU_SCB_CSR_EN
  logic r_csrPend;

  // One outstanding CSR write at a time. Set wins over clear so a new CSR
  // write issuing as the previous one retires stays tracked.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csrPend <= 1'b0;
    end else if (bus.i_flush) begin
      r_csrPend <= 1'b0;
    end else if (w_issue & bus.i_sysins & bus.i_csrdwen) begin
      r_csrPend <= 1'b1;
    end else if (bus.i_wb_csr) begin
      r_csrPend <= 1'b0;
    end
  end

  assign w_csrHazard = bus.i_sysins & r_csrPend;
`else
  logic w_unused;

  assign w_unused    = ^{bus.i_sysins, bus.i_csrdwen, bus.i_wb_csr};
  assign w_csrHazard = 1'b0;
`endif

endmodule

// File: tb/tb_idu_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_idu_scoreboard
// Self-checking bench for idu_scoreboard. A per-register count model updated
// from the hazard/issue/writeback rules is compared against the DUT outputs
// every cycle; directed scenarios add hand-computed literal expectations.
// Honours IDU_SCB_CSR_EN for the CSR serialisation expectations.
// -----------------------------------------------------------------------------
module tb_idu_scoreboard;
  import idu_scoreboard_pkg::*;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef IDU_SCB_CSR_EN
  localparam logic CSR_EN = 1'b1;
`else
  localparam logic CSR_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0] rs1;
    logic       rs1en;
    logic [4:0] rs2;
    logic       rs2en;
    logic [4:0] rd;
    logic       rdw;
    logic       sys;
    logic       csrw;
    logic       pv;
    logic       pr;
    logic       wbv;
    logic [4:0] wbrd;
    logic       wbcsr;
    logic       flush;
  } stim_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  int   mCnt [32];
  logic mCsrPend;
  logic mWbErr;

  always #5 clk = ~clk;

  idu_scoreboard_if bus ();

  idu_scoreboard #(
    .REG_NUM (32),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rs1 = 5'd0; s.rs1en = 1'b0; s.rs2 = 5'd0; s.rs2en = 1'b0;
    s.rd  = 5'd0; s.rdw   = 1'b0; s.sys = 1'b0; s.csrw  = 1'b0;
    s.pv  = 1'b0; s.pr    = 1'b1; s.wbv = 1'b0; s.wbrd  = 5'd0;
    s.wbcsr = 1'b0; s.flush = 1'b0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.i_rs1id      = s.rs1;
    bus.i_rs1ren     = s.rs1en;
    bus.i_rs2id      = s.rs2;
    bus.i_rs2ren     = s.rs2en;
    bus.i_rdid       = s.rd;
    bus.i_rdwen      = s.rdw;
    bus.i_sysins     = s.sys;
    bus.i_csrdwen    = s.csrw;
    bus.i_pre_valid  = s.pv;
    bus.i_post_ready = s.pr;
    bus.i_wb_valid   = s.wbv;
    bus.i_wb_rdid    = s.wbrd;
    bus.i_wb_csr     = s.wbcsr;
    bus.i_flush      = s.flush;
  endtask

  // Drives one cycle's inputs at the falling edge and returns 3 time units
  // later, after the per-cycle compare has run, so callers can add literals.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    drive(s);
    #3;
  endtask

  function automatic logic modelHazard();
    logic h;
    h = 1'b0;
    if (bus.i_rs1ren && bus.i_rs1id != 0 && mCnt[bus.i_rs1id] != 0) h = 1'b1;
    if (bus.i_rs2ren && bus.i_rs2id != 0 && mCnt[bus.i_rs2id] != 0) h = 1'b1;
    if (bus.i_rdwen && bus.i_rdid != 0 && mCnt[bus.i_rdid] == CNT_MAX) h = 1'b1;
    if (CSR_EN && bus.i_sysins && mCsrPend) h = 1'b1;
    return h;
  endfunction

  // Per-cycle compare: sample 2 units after the falling edge (inputs stable,
  // far from the rising edge), then advance the model to the post-edge state.
  initial begin
    int   nc [32];
    logic haz;
    logic issue;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        foreach (mCnt[i]) mCnt[i] = 0;
        mCsrPend = 1'b0;
        mWbErr   = 1'b0;
      end
      haz = modelHazard();
      checkOutput("cyc_stall", bus.o_stall, bus.i_pre_valid & haz);
      checkOutput("cyc_post_valid", bus.o_post_valid, bus.i_pre_valid & ~haz & ~bus.i_flush);
      checkOutput("cyc_pre_ready", bus.o_pre_ready, bus.i_post_ready & ~haz & ~bus.i_flush);
      checkOutput("cyc_wb_err", bus.o_wb_err, mWbErr);
      if (rst_n) begin
        issue = bus.i_pre_valid & ~haz & ~bus.i_flush & bus.i_post_ready;
        if (bus.i_flush) begin
          foreach (mCnt[i]) mCnt[i] = 0;
          mCsrPend = 1'b0;
        end else begin
          nc = mCnt;
          if (bus.i_wb_valid && bus.i_wb_rdid != 0) begin
            if (mCnt[bus.i_wb_rdid] == 0) mWbErr = 1'b1;
            else nc[bus.i_wb_rdid] = nc[bus.i_wb_rdid] - 1;
          end
          if (issue && bus.i_rdwen && bus.i_rdid != 0) nc[bus.i_rdid] = nc[bus.i_rdid] + 1;
          mCnt = nc;
          if (CSR_EN) begin
            if (issue && bus.i_sysins && bus.i_csrdwen) mCsrPend = 1'b1;
            else if (bus.i_wb_csr) mCsrPend = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.pr = 1'b0;
    drive(s);

    // Reset state: nothing pending, no error.
    s = idle();
    s.pv = 1'b1; s.rs1 = 5'd5; s.rs1en = 1'b1;
    applyStimulus(s);
    checkOutput("reset_stall", bus.o_stall, 1'b0);
    checkOutput("reset_wb_err", bus.o_wb_err, 1'b0);
    checkOutput("reset_post_valid", bus.o_post_valid, 1'b1);
    applyStimulus(idle());
    rst_n = 1'b1;

    // 1: RAW on x5 until its writeback has been registered.
    s = idle(); s.pv = 1'b1; s.rd = 5'd5; s.rdw = 1'b1;
    applyStimulus(s);
    checkOutput("t1_issue_valid", bus.o_post_valid, 1'b1);
    s = idle(); s.pv = 1'b1; s.rs1 = 5'd5; s.rs1en = 1'b1;
    applyStimulus(s);
    checkOutput("t1_raw_stall", bus.o_stall, 1'b1);
    checkOutput("t1_raw_valid", bus.o_post_valid, 1'b0);
    s.wbv = 1'b1; s.wbrd = 5'd5;
    applyStimulus(s);
    checkOutput("t1_no_bypass", bus.o_stall, 1'b1);
    s.wbv = 1'b0;
    applyStimulus(s);
    checkOutput("t1_released", bus.o_stall, 1'b0);
    checkOutput("t1_released_valid", bus.o_post_valid, 1'b1);

    // 2: x0 is never tracked; a writeback to x0 is silently ignored.
    s = idle(); s.pv = 1'b1; s.rd = 5'd0; s.rdw = 1'b1;
    repeat (3) applyStimulus(s);
    s = idle(); s.pv = 1'b1; s.rs1en = 1'b1; s.rs2en = 1'b1; s.wbv = 1'b1; s.wbrd = 5'd0;
    applyStimulus(s);
    checkOutput("t2_x0_nostall", bus.o_stall, 1'b0);
    applyStimulus(idle());
    checkOutput("t2_x0_wb_noerr", bus.o_wb_err, 1'b0);
    checkInt("t2_model_cnt0", mCnt[0], 0);

    // 3: counter saturation on x7 blocks the 4th writer until a retire.
    s = idle(); s.pv = 1'b1; s.rd = 5'd7; s.rdw = 1'b1;
    repeat (3) applyStimulus(s);
    applyStimulus(s);
    checkOutput("t3_full_stall", bus.o_stall, 1'b1);
    checkOutput("t3_full_ready", bus.o_pre_ready, 1'b0);
    s.wbv = 1'b1; s.wbrd = 5'd7;
    applyStimulus(s);
    checkOutput("t3_full_wb_same", bus.o_stall, 1'b1);
    s.wbv = 1'b0;
    applyStimulus(s);
    checkOutput("t3_full_issues", bus.o_post_valid, 1'b1);
    s = idle(); s.wbv = 1'b1; s.wbrd = 5'd7;
    repeat (3) applyStimulus(s);
    applyStimulus(idle());
    checkInt("t3_model_cnt7", mCnt[7], 0);

    // 4: issue and retire of x3 in the same cycle keep its count at 1.
    s = idle(); s.pv = 1'b1; s.rd = 5'd3; s.rdw = 1'b1;
    applyStimulus(s);
    s.wbv = 1'b1; s.wbrd = 5'd3;
    applyStimulus(s);
    checkOutput("t4_issue_with_wb", bus.o_post_valid, 1'b1);
    applyStimulus(idle());
    checkInt("t4_model_cnt3", mCnt[3], 1);
    s = idle(); s.pv = 1'b1; s.rs2 = 5'd3; s.rs2en = 1'b1;
    applyStimulus(s);
    checkOutput("t4_still_pending", bus.o_stall, 1'b1);
    s = idle(); s.wbv = 1'b1; s.wbrd = 5'd3;
    applyStimulus(s);
    s = idle(); s.pv = 1'b1; s.rs1 = 5'd3; s.rs1en = 1'b1;
    applyStimulus(s);
    checkOutput("t4_drained", bus.o_stall, 1'b0);

    // 5: flush blocks issue and clears x9's two pending writes.
    s = idle(); s.pv = 1'b1; s.rd = 5'd9; s.rdw = 1'b1;
    repeat (2) applyStimulus(s);
    s.flush = 1'b1;
    applyStimulus(s);
    checkOutput("t5_flush_valid", bus.o_post_valid, 1'b0);
    checkOutput("t5_flush_ready", bus.o_pre_ready, 1'b0);
    s = idle(); s.pv = 1'b1; s.rs1 = 5'd9; s.rs1en = 1'b1; s.rs2 = 5'd9; s.rs2en = 1'b1;
    applyStimulus(s);
    checkOutput("t5_after_flush", bus.o_stall, 1'b0);

    // 6: stray writeback to x4 raises a sticky error.
    s = idle(); s.wbv = 1'b1; s.wbrd = 5'd4;
    applyStimulus(s);
    checkOutput("t6_err_not_yet", bus.o_wb_err, 1'b0);
    applyStimulus(idle());
    checkOutput("t6_err_set", bus.o_wb_err, 1'b1);
    repeat (3) applyStimulus(idle());
    checkOutput("t6_err_sticky", bus.o_wb_err, 1'b1);

    // 7: csrrw then mret; serialised only when the CSR feature is built in.
    s = idle(); s.pv = 1'b1; s.sys = 1'b1; s.csrw = 1'b1;
    applyStimulus(s);
    checkOutput("t7_csr_issue", bus.o_post_valid, 1'b1);
    s = idle(); s.pv = 1'b1; s.sys = 1'b1;
    applyStimulus(s);
    checkOutput("t7_mret_stall", bus.o_stall, CSR_EN);
    s.wbcsr = 1'b1;
    applyStimulus(s);
    checkOutput("t7_mret_wb_same", bus.o_stall, CSR_EN);
    s.wbcsr = 1'b0;
    applyStimulus(s);
    checkOutput("t7_mret_release", bus.o_stall, 1'b0);

    // 8: EXU not ready: valid is offered but nothing issues.
    s = idle(); s.pv = 1'b1; s.pr = 1'b0; s.rd = 5'd10; s.rdw = 1'b1;
    applyStimulus(s);
    checkOutput("t8_valid_offered", bus.o_post_valid, 1'b1);
    checkOutput("t8_not_ready", bus.o_pre_ready, 1'b0);
    s = idle(); s.pv = 1'b1; s.rs1 = 5'd10; s.rs1en = 1'b1;
    applyStimulus(s);
    checkOutput("t8_no_issue", bus.o_stall, 1'b0);

    // 9: asynchronous reset mid-operation wipes counts and the error flag.
    s = idle(); s.pv = 1'b1; s.rd = 5'd6; s.rdw = 1'b1;
    applyStimulus(s);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t9_async_err_clr", bus.o_wb_err, 1'b0);
    applyStimulus(idle());
    rst_n = 1'b1;
    s = idle(); s.pv = 1'b1; s.rs1 = 5'd6; s.rs1en = 1'b1;
    applyStimulus(s);
    checkOutput("t9_cnt_cleared", bus.o_stall, 1'b0);

    applyStimulus(idle());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
